// File: rtl/net_stage_pkg.sv
// ============================================================================
// Module      : net_stage_pkg
// Description : Shared types and defaults for the net stage skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package net_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   localparam int NET_STAGE_DEFAULT_WIDTH = 8;

endpackage : net_stage_pkg

`default_nettype wire

// File: rtl/net_skid_buffer.sv
// ============================================================================
// Module      : net_skid_buffer
// Description : Two-entry registered skid buffer. Registers both the forward
//               (data/valid) and backward (ready) paths at one item per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module net_skid_buffer
   import net_stage_pkg::*;
#(
   parameter int WIDTH = NET_STAGE_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_e      r_state;
   skid_state_e      w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_accept;
   logic             w_consume;

   // Flags decode only legal states so an illegal encoding neither accepts
   // nor presents data during its single recovery cycle.
   assign in_ready  = (r_state == EMPTY) || (r_state == ONE);
   assign out_valid = (r_state == ONE)   || (r_state == FULL);
   assign out_data  = r_main;

   assign w_accept  = in_valid  && in_ready;
   assign w_consume = out_valid && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_main_nxt  = in_data;
               w_state_nxt = ONE;
            end
         end
         ONE: begin
            if (w_accept && w_consume) begin
               w_main_nxt = in_data;
            end else if (w_accept) begin
               w_skid_nxt  = in_data;
               w_state_nxt = FULL;
            end else if (w_consume) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_consume) begin
               w_main_nxt  = r_skid;
               w_state_nxt = ONE;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

endmodule : net_skid_buffer

`default_nettype wire

// File: tb/tb_net_skid_buffer.sv
// ============================================================================
// Module      : tb_net_skid_buffer
// Description : Directed bench for net_skid_buffer driving a one-net assign
//               stage; checks reset, latency, streaming, backpressure, FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_net_skid_buffer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   wire  [W-1:0] net_b;

   int n_vec;
   int n_err;

   net_skid_buffer #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Downstream continuous-assignment net stage.
   assign net_b = out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] exp_q[$];
      logic [W-1:0] exp_item;
      int           sent;
      int           rcvd;
      int           cyc;

      n_vec     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b0;

      // Reset held two cycles with a valid item presented.
      step();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      check_vec("rst_out_valid", 64'(out_valid), 64'd0);
      check_vec("rst_out_data",  64'(net_b),     64'h00);
      check_vec("rst_in_ready",  64'(in_ready),  64'd1);
      step();
      check_vec("rst_no_capture", 64'(out_valid), 64'd0);

      // Single item, one-cycle latency.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      step();
      in_valid = 1'b0;
      check_vec("single_valid", 64'(out_valid), 64'd1);
      check_vec("single_data",  64'(net_b),     64'h5A);
      step();
      check_vec("single_drain", 64'(out_valid), 64'd0);

      // Back-to-back stream 01..10.
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         check_vec("stream_in_ready", 64'(in_ready), 64'd1);
         if (i > 1) begin
            check_vec("stream_valid", 64'(out_valid), 64'd1);
            check_vec("stream_data",  64'(net_b),     64'(i - 1));
         end
         step();
      end
      in_valid = 1'b0;
      check_vec("stream_last_valid", 64'(out_valid), 64'd1);
      check_vec("stream_last_data",  64'(net_b),     64'h10);
      step();
      check_vec("stream_drain", 64'(out_valid), 64'd0);

      // Backpressure: 11 and 22 fill the buffer, 33 stalls upstream.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      check_vec("bp_ready0", 64'(in_ready), 64'd1);
      step();
      in_data = 8'h22;
      check_vec("bp_ready1", 64'(in_ready), 64'd1);
      step();
      in_data = 8'h33;
      check_vec("bp_full_ready", 64'(in_ready), 64'd0);
      check_vec("bp_full_data",  64'(net_b),    64'h11);
      step();
      check_vec("bp_hold_ready", 64'(in_ready), 64'd0);
      check_vec("bp_hold_data",  64'(net_b),    64'h11);
      check_vec("bp_hold_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      step();
      check_vec("bp_out22",      64'(net_b),    64'h22);
      check_vec("bp_ready_rise", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check_vec("bp_out33",   64'(net_b),     64'h33);
      check_vec("bp_valid33", 64'(out_valid), 64'd1);
      step();
      check_vec("bp_drain", 64'(out_valid), 64'd0);

      // Alternating out_ready with continuous input, 100 random items.
      sent = 0;
      rcvd = 0;
      cyc  = 0;
      out_ready = 1'b0;
      while ((rcvd < 100) && (cyc < 2000)) begin
         in_valid = (sent < 100);
         in_data  = 8'($urandom);
         out_ready = ~out_ready;
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            sent++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_vec("alt_spurious", 64'd1, 64'd0);
            end else begin
               exp_item = exp_q.pop_front();
               check_vec("alt_data", 64'(net_b), 64'(exp_item));
            end
            rcvd++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      check_vec("alt_count", 64'(rcvd), 64'd100);
      check_vec("alt_leftover", 64'(exp_q.size()), 64'd0);

      // Reset while FULL discards both items.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hC1;
      step();
      in_data = 8'hC2;
      step();
      in_valid = 1'b0;
      check_vec("rf_full", 64'(in_ready), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_vec("rf_valid", 64'(out_valid), 64'd0);
      check_vec("rf_ready", 64'(in_ready),  64'd1);
      check_vec("rf_data",  64'(net_b),     64'h00);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hD0;
      step();
      in_valid = 1'b0;
      check_vec("rf_first_valid", 64'(out_valid), 64'd1);
      check_vec("rf_first_data",  64'(net_b),     64'hD0);
      step();
      check_vec("rf_drain", 64'(out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_net_skid_buffer

`default_nettype wire
